// File: rtl/ycbcr_skin_bbox.sv
// Skin classifier on a YCbCr444 stream. It emits a 1-clk delayed binary mask
// and reports a per-frame bounding box and pixel count when each frame ends.
module ycbcr_skin_bbox #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int CB_MIN  = 77,
  parameter int CB_MAX  = 127,
  parameter int CR_MIN  = 133,
  parameter int CR_MAX  = 173,
  parameter int MIN_PIX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [7:0]  per_img_Y,
  input  logic [7:0]  per_img_Cb,
  input  logic [7:0]  per_img_Cr,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic        post_img_bit,
  output logic        box_valid,
  output logic        box_found,
  output logic [10:0] box_x_min,
  output logic [10:0] box_x_max,
  output logic [10:0] box_y_min,
  output logic [10:0] box_y_max,
  output logic [19:0] box_pix_cnt
);

  localparam logic [7:0]  CB_LO   = 8'(CB_MIN);
  localparam logic [7:0]  CB_HI   = 8'(CB_MAX);
  localparam logic [7:0]  CR_LO   = 8'(CR_MIN);
  localparam logic [7:0]  CR_HI   = 8'(CR_MAX);
  localparam logic [11:0] X_LIM   = 12'(IMG_W);
  localparam logic [11:0] Y_LIM   = 12'(IMG_H);
  localparam logic [19:0] MIN_CNT = 20'(MIN_PIX);
  localparam logic [10:0] COORD_MAX = 11'h7FF;
  localparam logic [19:0] CNT_MAX   = 20'hFFFFF;

  logic        vsync_q, href_q, clken_q, mask_q, primed_q;
  logic [10:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [10:0] acc_x_min_q, acc_x_min_d, acc_x_max_q, acc_x_max_d;
  logic [10:0] acc_y_min_q, acc_y_min_d, acc_y_max_q, acc_y_max_d;
  logic [19:0] acc_cnt_q, acc_cnt_d;
  logic        armed_q, armed_d;
  logic        box_valid_q, box_valid_d, box_found_q, box_found_d;
  logic [10:0] box_x_min_q, box_x_min_d, box_x_max_q, box_x_max_d;
  logic [10:0] box_y_min_q, box_y_min_d, box_y_max_q, box_y_max_d;
  logic [19:0] box_cnt_q, box_cnt_d;

  logic skin, in_roi, pix_hit, frame_start, frame_end;
  logic luma_unused;

  assign luma_unused = ^per_img_Y;

  assign skin = (per_img_Cb >= CB_LO) && (per_img_Cb <= CB_HI) &&
                (per_img_Cr >= CR_LO) && (per_img_Cr <= CR_HI);
  assign in_roi  = ({1'b0, x_cnt_q} < X_LIM) && ({1'b0, y_cnt_q} < Y_LIM);
  assign pix_hit = per_frame_vsync & per_frame_href & per_frame_clken & skin & in_roi;

  // vsync_q only reflects a real sample once primed_q is set, so releasing
  // reset in the middle of a frame is not mistaken for a frame start.
  assign frame_start = per_frame_vsync & ~vsync_q & primed_q;
  assign frame_end   = ~per_frame_vsync & vsync_q & armed_q;

  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (!per_frame_href) begin
      x_cnt_d = '0;
    end else if (per_frame_clken && (x_cnt_q != COORD_MAX)) begin
      x_cnt_d = x_cnt_q + 11'd1;
    end
    if (!per_frame_vsync) begin
      y_cnt_d = '0;
    end else if (href_q && !per_frame_href && (y_cnt_q != COORD_MAX)) begin
      y_cnt_d = y_cnt_q + 11'd1;
    end
  end

  always_comb begin
    acc_x_min_d = acc_x_min_q;
    acc_x_max_d = acc_x_max_q;
    acc_y_min_d = acc_y_min_q;
    acc_y_max_d = acc_y_max_q;
    acc_cnt_d   = acc_cnt_q;
    armed_d     = armed_q;
    if (frame_start) begin
      acc_x_min_d = COORD_MAX;
      acc_x_max_d = '0;
      acc_y_min_d = COORD_MAX;
      acc_y_max_d = '0;
      acc_cnt_d   = '0;
      armed_d     = 1'b1;
    end else if (pix_hit) begin
      if (x_cnt_q < acc_x_min_q) acc_x_min_d = x_cnt_q;
      if (x_cnt_q > acc_x_max_q) acc_x_max_d = x_cnt_q;
      if (y_cnt_q < acc_y_min_q) acc_y_min_d = y_cnt_q;
      if (y_cnt_q > acc_y_max_q) acc_y_max_d = y_cnt_q;
      if (acc_cnt_q != CNT_MAX)  acc_cnt_d   = acc_cnt_q + 20'd1;
    end
    if (frame_end) begin
      armed_d = 1'b0;
    end
  end

  always_comb begin
    box_valid_d = 1'b0;
    box_found_d = box_found_q;
    box_x_min_d = box_x_min_q;
    box_x_max_d = box_x_max_q;
    box_y_min_d = box_y_min_q;
    box_y_max_d = box_y_max_q;
    box_cnt_d   = box_cnt_q;
    if (frame_end) begin
      box_valid_d = 1'b1;
      box_cnt_d   = acc_cnt_q;
      if (acc_cnt_q >= MIN_CNT) begin
        box_found_d = 1'b1;
        box_x_min_d = acc_x_min_q;
        box_x_max_d = acc_x_max_q;
        box_y_min_d = acc_y_min_q;
        box_y_max_d = acc_y_max_q;
      end else begin
        box_found_d = 1'b0;
        box_x_min_d = '0;
        box_x_max_d = '0;
        box_y_min_d = '0;
        box_y_max_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      clken_q     <= 1'b0;
      mask_q      <= 1'b0;
      primed_q    <= 1'b0;
      x_cnt_q     <= '0;
      y_cnt_q     <= '0;
      acc_x_min_q <= '0;
      acc_x_max_q <= '0;
      acc_y_min_q <= '0;
      acc_y_max_q <= '0;
      acc_cnt_q   <= '0;
      armed_q     <= 1'b0;
      box_valid_q <= 1'b0;
      box_found_q <= 1'b0;
      box_x_min_q <= '0;
      box_x_max_q <= '0;
      box_y_min_q <= '0;
      box_y_max_q <= '0;
      box_cnt_q   <= '0;
    end else begin
      vsync_q     <= per_frame_vsync;
      href_q      <= per_frame_href;
      clken_q     <= per_frame_clken;
      mask_q      <= skin;
      primed_q    <= 1'b1;
      x_cnt_q     <= x_cnt_d;
      y_cnt_q     <= y_cnt_d;
      acc_x_min_q <= acc_x_min_d;
      acc_x_max_q <= acc_x_max_d;
      acc_y_min_q <= acc_y_min_d;
      acc_y_max_q <= acc_y_max_d;
      acc_cnt_q   <= acc_cnt_d;
      armed_q     <= armed_d;
      box_valid_q <= box_valid_d;
      box_found_q <= box_found_d;
      box_x_min_q <= box_x_min_d;
      box_x_max_q <= box_x_max_d;
      box_y_min_q <= box_y_min_d;
      box_y_max_q <= box_y_max_d;
      box_cnt_q   <= box_cnt_d;
    end
  end

  assign post_frame_vsync = vsync_q;
  assign post_frame_href  = href_q;
  assign post_frame_clken = clken_q;
  assign post_img_bit     = href_q & mask_q;
  assign box_valid        = box_valid_q;
  assign box_found        = box_found_q;
  assign box_x_min        = box_x_min_q;
  assign box_x_max        = box_x_max_q;
  assign box_y_min        = box_y_min_q;
  assign box_y_max        = box_y_max_q;
  assign box_pix_cnt      = box_cnt_q;

endmodule
